// File: rtl/instr_sequencer.sv
// Instruction fetch/sequence unit: fetches {opcode, operand} over req/ack and steps the PC.
// Optional single-step mode is enabled by defining SEQ_STEP_EN.
module instr_sequencer #(
    parameter int unsigned    PC_W   = 5,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef SEQ_STEP_EN
    input  logic              step,
`endif
    input  logic              run,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [PC_W+2:0]   imem_rdata,
    output logic [2:0]        opcode,
    output logic [PC_W-1:0]   operand,
    input  logic              jump,
    output logic              exec,
    output logic [PC_W-1:0]   pc,
    output logic              busy
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StFetch   = 2'd1;
    localparam logic [1:0] StDecode  = 2'd2;
    localparam logic [1:0] StExecute = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W+2:0] ir_q, ir_d;
    logic            req_q, req_d;
    logic            exec_q, exec_d;
    logic            busy_q, busy_d;
    logic            start_ok;
    logic            resume_ok;

`ifdef SEQ_STEP_EN
    logic step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    // Each rising step edge admits exactly one instruction.
    assign start_ok  = run && step && !step_q;
    assign resume_ok = 1'b0;
`else
    assign start_ok  = run;
    assign resume_ok = run;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (req_q && imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = StExecute;
            end
            StExecute: begin
                pc_d    = jump ? ir_q[PC_W-1:0] : pc_q + 1'b1;
                state_d = resume_ok ? StFetch : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Outputs are decoded from the next state so they leave the block registered.
        req_d  = (state_d == StFetch);
        exec_d = (state_d == StExecute);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RST_PC;
            ir_q    <= '0;
            req_q   <= 1'b0;
            exec_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            req_q   <= req_d;
            exec_q  <= exec_d;
            busy_q  <= busy_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign opcode    = ir_q[PC_W+2:PC_W];
    assign operand   = ir_q[PC_W-1:0];
    assign exec      = exec_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: transaction-level model of fetch/decode/execute with random memory,
// wait states, jumps and run drops. Covers single-step mode when SEQ_STEP_EN is defined.
module tb_instr_sequencer;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       imem_req;
    logic [4:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic [2:0] opcode;
    logic [4:0] operand;
    logic       jump;
    logic       exec;
    logic [4:0] pc;
    logic       busy;
`ifdef SEQ_STEP_EN
    logic       step;
    localparam bit StepMode = 1'b1;
`else
    localparam bit StepMode = 1'b0;
`endif

    instr_sequencer #(
        .PC_W   (5),
        .RST_PC (5'd0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef SEQ_STEP_EN
        .step       (step),
`endif
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .opcode     (opcode),
        .operand    (operand),
        .jump       (jump),
        .exec       (exec),
        .pc         (pc),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total;
    int         passed;
    int         fails;
    logic [7:0] mem [32];
    logic [4:0] pc_m;
    logic [7:0] ir_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input bit req_e, input bit exec_e, input bit busy_e);
        chk("imem_req", 32'(imem_req), 32'(req_e));
        chk("imem_addr", 32'(imem_addr), 32'(pc_m));
        chk("pc", 32'(pc), 32'(pc_m));
        chk("exec", 32'(exec), 32'(exec_e));
        chk("busy", 32'(busy), 32'(busy_e));
        chk("opcode", 32'(opcode), 32'(ir_m[7:5]));
        chk("operand", 32'(operand), 32'(ir_m[4:0]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_step(input bit v);
`ifdef SEQ_STEP_EN
        step = v;
`else
        if (v) begin
            run = run;
        end
`endif
    endtask

    // Noise on inputs that must be ignored in the current cycle.
    task automatic noise();
        imem_ack   = 1'($urandom);
        imem_rdata = 8'($urandom);
        jump       = 1'($urandom);
    endtask

    task automatic idle_cycles(input int n, input bit r);
        for (int i = 0; i < n; i++) begin
            run = r;
            drive_step(1'b0);
            noise();
            tick();
            chk_outs(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic start_run();
        run = 1'b1;
        drive_step(1'b1);
        noise();
        tick();
        drive_step(1'b0);
    endtask

    // One instruction from its first FETCH cycle through EXECUTE.
    task automatic do_instr(input int waits, input bit jmp, input bit run_next,
                            output bit went_idle);
        for (int w = 0; w <= waits; w++) begin
            chk_outs(1'b1, 1'b0, 1'b1);
            imem_ack   = (w == waits);
            imem_rdata = (w == waits) ? mem[pc_m] : 8'($urandom);
            jump       = 1'($urandom);
            run        = 1'($urandom);
            tick();
        end
        ir_m = mem[pc_m];
        chk_outs(1'b0, 1'b0, 1'b1);
        noise();
        run = 1'($urandom);
        tick();
        chk_outs(1'b0, 1'b1, 1'b1);
        noise();
        jump = jmp;
        run  = run_next;
        tick();
        pc_m = jmp ? ir_m[4:0] : pc_m + 5'd1;
        went_idle = !run_next || StepMode;
        if (went_idle) begin
            chk_outs(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        bit idle;
        total  = 0;
        passed = 0;
        fails  = 0;
        rst_n  = 1'b0;
        run    = 1'b0;
        drive_step(1'b0);
        imem_ack   = 1'b0;
        imem_rdata = 8'h00;
        jump       = 1'b0;
        pc_m = 5'd0;
        ir_m = 8'h00;
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);

        #12;
        chk_outs(1'b0, 1'b0, 1'b0);
        #6 rst_n = 1'b1;
        tick();
        chk_outs(1'b0, 1'b0, 1'b0);
        idle_cycles(2, 1'b0);

        if (StepMode) begin
            // run alone must not leave IDLE
            idle_cycles(3, 1'b1);
            for (int k = 0; k < 3; k++) begin
                start_run();
                do_instr($urandom_range(0, 2), 1'b0, 1'b1, idle);
                idle_cycles(2, 1'b1);
            end
            chk("step_pc", 32'(pc), 32'd3);
        end else begin
            mem[0] = 8'h20;
            mem[1] = 8'h41;
            mem[2] = 8'h62;
            start_run();
            do_instr(0, 1'b0, 1'b1, idle);
            do_instr(0, 1'b0, 1'b1, idle);
            do_instr(0, 1'b0, 1'b1, idle);
            do_instr(2, 1'b0, 1'b1, idle);
            // run drops: instruction at 4 completes, then IDLE at 5
            do_instr(0, 1'b0, 1'b0, idle);
            idle_cycles(2, 1'b0);
            mem[5]  = 8'hDF;
            mem[31] = 8'h3A;
            start_run();
            do_instr(0, 1'b1, 1'b1, idle);
            do_instr(1, 1'b0, 1'b1, idle);
            chk("wrap_pc", 32'(pc), 32'd0);
            mem[0] = 8'hC5;
            do_instr(0, 1'b1, 1'b1, idle);
            chk("jump_addr", 32'(imem_addr), 32'd5);

            // Reset during a wait state; the late ack must be ignored.
            chk_outs(1'b1, 1'b0, 1'b1);
            imem_ack = 1'b0;
            tick();
            chk_outs(1'b1, 1'b0, 1'b1);
            #2 rst_n = 1'b0;
            #1;
            pc_m = 5'd0;
            ir_m = 8'h00;
            chk_outs(1'b0, 1'b0, 1'b0);
            imem_ack   = 1'b1;
            imem_rdata = 8'hFF;
            run        = 1'b0;
            #2 rst_n = 1'b1;
            tick();
            chk_outs(1'b0, 1'b0, 1'b0);
            idle_cycles(1, 1'b0);

            for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
            start_run();
            for (int i = 0; i < 60; i++) begin
                do_instr($urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                         ($urandom_range(0, 5) != 0), idle);
                if (idle) begin
                    idle_cycles($urandom_range(0, 2), 1'b0);
                    start_run();
                end
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction fetch/sequence unit for the 8-bit accumulator processor. It fetches 8-bit instructions from instruction memory over a req/ack handshake and presents the 3-bit opcode and 5-bit operand to the control unit and datapath. It consumes the control unit's `jump` decision to select the next program counter. It is the producer of the opcode stream and the consumer of the jump result that the control unit generates.

## Interface
Parameters:
- `PC_W`, default 5: program counter and operand width; the instruction is `{opcode[2:0], operand[PC_W-1:0]}`.
- `RST_PC`, default 0: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; high permits fetching; low stops at the next instruction boundary.
- `imem_req`  out  1  instruction fetch request, registered.
- `imem_addr`  out  PC_W  fetch address; equals `pc`.
- `imem_ack`  in  1  memory response; `imem_rdata` is valid on any cycle where `imem_req && imem_ack`.
- `imem_rdata`  in  3+PC_W  fetched instruction.
- `opcode`  out  3  `IR[7:5]`, to the control unit.
- `operand`  out  PC_W  `IR[4:0]`, memory address / jump target.
- `jump`  in  1  from the control unit; sampled only in EXECUTE.
- `exec`  out  1  one-cycle commit strobe for the datapath (acc/mem write enables).
- `pc`  out  PC_W  current program counter.
- `busy`  out  1  high in any state other than IDLE.
- `step`  in  1  present only with `SEQ_STEP_EN`.

## Operation
- The state machine has four states: IDLE, FETCH, DECODE, EXECUTE.
- **IDLE:** `imem_req`=0, `exec`=0. If `run`=1 (and the step condition holds, see Configuration), go to FETCH.
- **FETCH:** `imem_req`=1 and `imem_addr`=`pc` are held stable until the handshake completes.
  - On an edge with `imem_req && imem_ack`: IR is loaded from `imem_rdata`, `imem_req` drops, and the state goes to DECODE.
  - `imem_ack` while `imem_req`=0 is ignored.
- **DECODE:** one cycle that lets the control unit settle on the new `opcode`. Go to EXECUTE.
- **EXECUTE:** `exec`=1 for exactly this cycle. At the closing edge:
  - `pc` is loaded with `operand` if `jump`=1, otherwise with `pc+1`.
  - The state goes to FETCH if `run`=1, otherwise to IDLE.
- PC arithmetic is modulo 2^PC_W: `pc`=31 increments to 0 with no flag.
- IR, and therefore `opcode`/`operand`, changes only on a fetch handshake edge. It holds from DECODE until the next completed fetch, including while in IDLE.
- When `run` falls mid-instruction, the instruction still completes through EXECUTE, including the PC update, and then the state goes to IDLE.
- Reset values: state IDLE, `pc`=RST_PC, IR=0 (`opcode`=0, `operand`=0), `imem_req`=0, `exec`=0, `busy`=0.
- When `rst_n` is asserted mid-operation, every output is forced to its reset value immediately. An outstanding request is abandoned, and any late `imem_ack` is ignored.

## Timing
- All outputs are registered. `imem_addr`, `opcode` and `operand` are direct register outputs.
- With zero-wait memory (ack on the first FETCH cycle), one instruction takes 3 cycles: FETCH, DECODE, EXECUTE. `exec` pulses every 3rd cycle.
- Each wait state on `imem_ack` adds one FETCH cycle. `imem_req` and `imem_addr` do not change during wait states.
- From `run` sampled high in IDLE, `imem_req` rises on the next cycle.
- A jump target is visible on `imem_addr` in the first FETCH cycle after EXECUTE. There is no delay slot and no flush.

## Configuration
- `SEQ_STEP_EN` defined:
  - The `step` port exists.
  - Leaving IDLE requires `run`=1 and a rising edge of `step`, detected with a registered copy of `step` (reset value 0).
  - After EXECUTE the state always returns to IDLE, so each step edge executes exactly one instruction.
- `SEQ_STEP_EN` undefined:
  - The `step` port is absent.
  - Behaviour is as in Operation: free-running while `run`=1.

## Test plan
- **Reset:** hold `rst_n`=0, then release with `run`=0 → `imem_req`=0, `pc`=0, `opcode`=0, `operand`=0, `exec`=0, `busy`=0, and the state stays IDLE.
- **Zero-wait sequencing:** `run`=1, ack on every request, memory 0x20/0x41/0x62, `jump`=0 → `imem_addr` 0,1,2; `opcode` 1,2,3 in their DECODE cycles; `exec` high every 3rd cycle.
- **Wait states:** ack delayed 2 cycles at address 3 → `imem_req`=1 and `imem_addr`=3 held for 3 cycles; the instruction takes 5 cycles total.
- **Jump and wrap:**
  - Instruction 0xC5 (opcode 110, operand 5) with `jump`=1 in EXECUTE → next `imem_addr`=5.
  - Non-jump instruction at `pc`=31 → next `imem_addr`=0.
- **Stop and reset mid-operation:**
  - `run` dropped during FETCH at `pc`=4 → the instruction completes, the state goes to IDLE, and `pc`=5.
  - `rst_n` pulsed low during a wait state → `imem_req` drops immediately, `pc`=0, and a subsequent ack is ignored.
- **`SEQ_STEP_EN`:** `run`=1, three `step` pulses → exactly three `exec` pulses, with `pc` going 0→1→2→3 and `busy`=0 between steps.
